// File: rtl/hash_arb_pkg.sv
// Shared types and constants for the lookup3 hash request arbiter.
//   HASH_W / KEY_W / LEN_W : widths of hash value, key word and key length
//   MAX_KEY_BYTES          : largest key the core hashes (three 32-bit words)
//   MAX_ID_W               : requester ID width for the widest legal N_REQ (8)
//   rsp_entry_t            : result FIFO entry {id, hash}
package hash_arb_pkg;

  localparam int unsigned HASH_W        = 32;
  localparam int unsigned KEY_W         = 32;
  localparam int unsigned LEN_W         = 8;
  localparam int unsigned MAX_KEY_BYTES = 12;
  localparam int unsigned MAX_ID_W      = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [HASH_W-1:0]   hash;
  } rsp_entry_t;

  // Increment modulo n, used for the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/hash_arb_fifo.sv
// Synchronous result FIFO for the hash arbiter.
//   CLK, RST  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i (ignored when full)
//   pop_i     : drop head entry (ignored when empty)
//   rdata_o   : head entry, meaningful only while !empty_o
//   full_o, empty_o, count_o : occupancy status
// No bypass: a push into an empty FIFO is visible at the head one cycle later.
module hash_arb_fifo
  import hash_arb_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            push_i,
  input  rsp_entry_t      wdata_i,
  input  logic            pop_i,
  output rsp_entry_t      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  rsp_entry_t     mem_q [Depth];
  logic           do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign count_o = CntW'(wr_ptr_q - rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/hash_req_arbiter.sv
// Shares one fully pipelined lookup3 core among N_REQ requesters.
//   CLK, RST                 : clock, synchronous active-high reset
//   req_valid/req_ready      : per-requester key handshake (ready is one-hot or zero)
//   req_key_length, req_k0..2: per-requester key, slice i belongs to requester i
//   hash_key_length, hash_k* : registered key presented to the core (zero when idle)
//   hash_hashkey             : core result, HASH_LAT cycles after the key is presented
//   rsp_valid/rsp_ready      : result handshake, rsp_id/rsp_hash = FIFO head
// Optional build macro HASH_ARB_STATS_EN adds stat_issue (per-requester transfer counts)
// and stat_stall (cycles with a request pending but no credit).
// Issue is credit-limited to FIFO_DEPTH outstanding keys, so the FIFO can never overflow.
module hash_req_arbiter
  import hash_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned HASH_LAT   = 110,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned ID_W      = $clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*LEN_W-1:0] req_key_length,
  input  logic [N_REQ*KEY_W-1:0] req_k0,
  input  logic [N_REQ*KEY_W-1:0] req_k1,
  input  logic [N_REQ*KEY_W-1:0] req_k2,
  output logic [LEN_W-1:0]       hash_key_length,
  output logic [KEY_W-1:0]       hash_k0,
  output logic [KEY_W-1:0]       hash_k1,
  output logic [KEY_W-1:0]       hash_k2,
  input  logic [HASH_W-1:0]      hash_hashkey,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [HASH_W-1:0]      rsp_hash
`ifdef HASH_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]    stat_issue,
  output logic [31:0]            stat_stall
`endif
);

  localparam int unsigned CredW = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic             transfer;
  logic [CredW-1:0] credits_q, credits_d;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign transfer = grant_vld && (credits_q != '0);

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant_id] = 1'b1;
  end

  // Key mux for the granted requester.
  logic [LEN_W-1:0] sel_len;
  logic [KEY_W-1:0] sel_k0, sel_k1, sel_k2;

  always_comb begin
    sel_len = '0;
    sel_k0  = '0;
    sel_k1  = '0;
    sel_k2  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_len = req_key_length[i*LEN_W +: LEN_W];
        sel_k0  = req_k0[i*KEY_W +: KEY_W];
        sel_k1  = req_k1[i*KEY_W +: KEY_W];
        sel_k2  = req_k2[i*KEY_W +: KEY_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Core input registers and round-robin pointer
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] hash_len_q;
  logic [KEY_W-1:0] hash_k0_q, hash_k1_q, hash_k2_q;

  always_ff @(posedge CLK) begin
    if (RST || !transfer) begin
      hash_len_q <= '0;
      hash_k0_q  <= '0;
      hash_k1_q  <= '0;
      hash_k2_q  <= '0;
    end else begin
      hash_len_q <= sel_len;
      hash_k0_q  <= sel_k0;
      hash_k1_q  <= sel_k1;
      hash_k2_q  <= sel_k2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q <= '0;
    end else if (transfer) begin
      rr_ptr_q <= ID_W'(wrap_inc(32'(grant_id), N_REQ));
    end
  end

  assign hash_key_length = hash_len_q;
  assign hash_k0         = hash_k0_q;
  assign hash_k1         = hash_k1_q;
  assign hash_k2         = hash_k2_q;

  // ---------------------------------------------------------------------------
  // Tag pipe: stage 0 sits beside the hash_* registers, stages 1..HASH_LAT follow
  // the core, so the tail describes the key whose result is on hash_hashkey now.
  // Clearing it on reset discards results of keys issued before reset.
  // ---------------------------------------------------------------------------
  logic [HASH_LAT:0] tag_vld_q;
  logic [ID_W-1:0]   tag_id_q [HASH_LAT+1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i <= HASH_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[HASH_LAT-1:0], transfer};
      tag_id_q[0] <= transfer ? grant_id : '0;
      for (int unsigned i = 1; i <= HASH_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  rsp_entry_t         push_entry, fifo_head;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CredW-1:0]   fifo_count;
  logic [MAX_ID_W-1:0] tail_id_ext;

  always_comb begin
    tail_id_ext           = '0;
    tail_id_ext[ID_W-1:0] = tag_id_q[HASH_LAT];
    push_entry.id         = tail_id_ext;
    push_entry.hash       = hash_hashkey;
  end

  assign fifo_push = tag_vld_q[HASH_LAT];
  assign fifo_pop  = rsp_valid && rsp_ready;

  hash_arb_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = fifo_empty ? '0 : fifo_head.id[ID_W-1:0];
  assign rsp_hash  = fifo_empty ? '0 : fifo_head.hash;

  // ---------------------------------------------------------------------------
  // Credits: one per FIFO slot, held by a key from issue until its result is popped.
  // ---------------------------------------------------------------------------
  always_comb begin
    credits_d = credits_q;
    case ({transfer, fifo_pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) credits_q <= CredW'(FIFO_DEPTH);
    else     credits_q <= credits_d;
  end

  // Buffered results never exceed outstanding keys; pushing into a full FIFO would drop one.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(fifo_push && fifo_full));
      assert (32'(fifo_count) + 32'(credits_q) <= FIFO_DEPTH);
      assert (fifo_empty || ((fifo_head.id >> ID_W) == '0));
    end
  end

`ifdef HASH_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters, wrapping at 2^32
  // ---------------------------------------------------------------------------
  logic [31:0] stat_issue_q [N_REQ];
  logic [31:0] stat_stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < N_REQ; i++) stat_issue_q[i] <= '0;
      stat_stall_q <= '0;
    end else begin
      if (transfer) stat_issue_q[grant_id] <= stat_issue_q[grant_id] + 32'd1;
      if ((|req_valid) && (credits_q == '0)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  always_comb begin
    stat_issue = '0;
    for (int unsigned i = 0; i < N_REQ; i++) stat_issue[i*32 +: 32] = stat_issue_q[i];
  end

  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Self-checking bench for hash_req_arbiter: lookup3 core model with a delay line,
// a queue-based reference of issue/credit/response behaviour checked every cycle,
// and directed scenarios with literal expectations.
module tb_hash_req_arbiter;
  import hash_arb_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned L   = 110;
  localparam int unsigned D   = 16;
  localparam int unsigned IDW = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*8-1:0]   req_key_length = '0;
  logic [N*32-1:0]  req_k0 = '0, req_k1 = '0, req_k2 = '0;
  logic [7:0]       hash_key_length;
  logic [31:0]      hash_k0, hash_k1, hash_k2, hash_hashkey;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IDW-1:0]   rsp_id;
  logic [31:0]      rsp_hash;
`ifdef HASH_ARB_STATS_EN
  logic [N*32-1:0]  stat_issue;
  logic [31:0]      stat_stall;
`endif

  always #5 CLK = ~CLK;

  hash_req_arbiter #(
    .N_REQ      (N),
    .HASH_LAT   (L),
    .FIFO_DEPTH (D)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_key_length  (req_key_length),
    .req_k0          (req_k0),
    .req_k1          (req_k1),
    .req_k2          (req_k2),
    .hash_key_length (hash_key_length),
    .hash_k0         (hash_k0),
    .hash_k1         (hash_k1),
    .hash_k2         (hash_k2),
    .hash_hashkey    (hash_hashkey),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_hash        (rsp_hash)
`ifdef HASH_ARB_STATS_EN
    ,
    .stat_issue      (stat_issue),
    .stat_stall      (stat_stall)
`endif
  );

  // ---------------------------------------------------------------------------
  // Golden lookup3 (hashlittle, initval 0) for keys up to 12 bytes
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] rot(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] lookup3(input logic [31:0] k0, input logic [31:0] k1,
                                          input logic [31:0] k2, input logic [7:0] len);
    logic [31:0] a, b, c, m [3];
    int n;
    a = 32'hdeadbeef + {24'd0, len};
    b = a;
    c = a;
    if (len == 8'd0) return c;
    n = (len > MAX_KEY_BYTES) ? MAX_KEY_BYTES : int'(len);
    for (int w = 0; w < 3; w++) begin
      int nb;
      nb = n - 4 * w;
      if (nb <= 0)     m[w] = 32'h0;
      else if (nb >= 4) m[w] = 32'hffffffff;
      else             m[w] = (32'h1 << (8 * nb)) - 32'h1;
    end
    a += k0 & m[0];
    b += k1 & m[1];
    c += k2 & m[2];
    c ^= b; c -= rot(b, 14);
    a ^= c; a -= rot(c, 11);
    b ^= a; b -= rot(a, 25);
    c ^= b; c -= rot(b, 16);
    a ^= c; a -= rot(c, 4);
    b ^= a; b -= rot(a, 14);
    c ^= b; c -= rot(b, 24);
    return c;
  endfunction

  // Core model: result of the key presented in cycle t appears in cycle t+L.
  logic [31:0] dl [L];
  always @(posedge CLK) begin
    for (int i = L - 1; i > 0; i--) dl[i] <= dl[i-1];
    dl[0] <= lookup3(hash_k0, hash_k1, hash_k2, hash_key_length);
  end
  assign hash_hashkey = dl[L-1];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outstanding keys as a queue, credits = D minus outstanding.
  bit          mon_en = 1'b0;
  int          cyc    = 0;
  int          rr_m   = 0;
  int          cred_m = D;
  int          q_id [$];
  logic [31:0] q_hash [$];
  int          q_avail [$];
  logic [103:0] exp_hin = '0;

  always @(negedge CLK) begin
    if (mon_en) begin
      int g;
      logic [N-1:0] exp_rdy;
      bit rv;
      g = -1;
      if (cred_m > 0)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("hash_in", 64'({hash_key_length, hash_k0, hash_k1, hash_k2} ^ exp_hin) , 64'd0);
      rv = (q_id.size() > 0) && (q_avail[0] <= cyc);
      check("rsp_valid", 64'(rsp_valid), 64'(rv));
      if (rv) begin
        check("rsp_id", 64'(rsp_id), 64'(q_id[0]));
        check("rsp_hash", 64'(rsp_hash), 64'(q_hash[0]));
      end
      if (RST) begin
        q_id.delete(); q_hash.delete(); q_avail.delete();
        rr_m = 0; cred_m = D; exp_hin = '0;
      end else begin
        if (rv && rsp_ready) begin
          void'(q_id.pop_front()); void'(q_hash.pop_front()); void'(q_avail.pop_front());
          cred_m++;
        end
        if (g >= 0) begin
          exp_hin = {req_key_length[g*8 +: 8], req_k0[g*32 +: 32], req_k1[g*32 +: 32],
                     req_k2[g*32 +: 32]};
          q_id.push_back(g);
          q_hash.push_back(lookup3(req_k0[g*32 +: 32], req_k1[g*32 +: 32], req_k2[g*32 +: 32],
                                   req_key_length[g*8 +: 8]));
          q_avail.push_back(cyc + L + 2);
          rr_m = (g + 1) % N;
          cred_m--;
        end else begin
          exp_hin = '0;
        end
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_key(input int r, input logic [7:0] len, input logic [31:0] k0,
                         input logic [31:0] k1, input logic [31:0] k2);
    req_key_length[r*8 +: 8] = len;
    req_k0[r*32 +: 32] = k0;
    req_k1[r*32 +: 32] = k1;
    req_k2[r*32 +: 32] = k2;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return 99;
  endfunction

  // Issue up to `offered` cycles of requests from requester r; returns accepted count.
  task automatic offer(input int r, input int offered, input int stop_at, output int acc);
    acc = 0;
    for (int i = 0; i < offered && acc < stop_at; i++) begin
      set_key(r, 8'd12, 32'h1000 + acc, 32'h2000 + r, 32'h3000 + i);
      req_valid[r] = 1'b1;
      @(negedge CLK);
      if (req_ready[r]) acc++;
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int n, acc, pops, stalls;
    int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_alt [4] = '{1, 3, 1, 3};

    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    RST = 1'b0;

    // Reset state
    @(negedge CLK);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_hash", 64'(rsp_hash), 64'd0);
    check("rst_hash_k0", 64'(hash_k0), 64'd0);
    tick();

    // 1: single key "abcd""efgh""ijkl" from requester 0
    rsp_ready = 1'b1;
    set_key(0, 8'd12, 32'h64636261, 32'h68676665, 32'h6c6b6a69);
    req_valid = 4'b0001;
    @(negedge CLK);
    check("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    n = 1;
    while (n < 300) begin
      @(negedge CLK);
      if (rsp_valid) break;
      n++;
    end
    check("t1_latency", 64'(n), 64'd112);
    check("t1_id", 64'(rsp_id), 64'd0);
    check("t1_hash", 64'(rsp_hash), 64'(lookup3(32'h64636261, 32'h68676665, 32'h6c6b6a69, 8'd12)));
    tick();

    // Zero-length key from requester 2: lookup3 returns the seed 0xdeadbeef
    set_key(2, 8'd0, 32'h11111111, 32'h22222222, 32'h33333333);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    n = 1;
    while (n < 300) begin
      @(negedge CLK);
      if (rsp_valid) break;
      n++;
    end
    check("len0_id", 64'(rsp_id), 64'd2);
    check("len0_hash", 64'(rsp_hash), 64'hdeadbeef);
    tick();

    // 2: fairness, all requesters valid, then only 1 and 3
    pulse_reset();
    for (int r = 0; r < N; r++) set_key(r, 8'(4 * r + 1), 32'hA0 + r, 32'hB0 + r, 32'hC0 + r);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("t2_grant", 64'(oh_idx(req_ready)), 64'(exp_seq[i]));
      tick();
    end
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t2_grant_alt", 64'(oh_idx(req_ready)), 64'(exp_alt[i]));
      tick();
    end
    req_valid = '0;
    repeat (L + 20) tick();

    // 3: backpressure, credits cap outstanding keys at FIFO depth
    pulse_reset();
    rsp_ready = 1'b0;
    offer(0, 20, 100, acc);
    check("t3_accepted", 64'(acc), 64'd16);
    @(negedge CLK);
    check("t3_ready_zero", 64'(req_ready), 64'd0);
`ifdef HASH_ARB_STATS_EN
    check("t6_stat_issue0", 64'(stat_issue[31:0]), 64'd16);
    check("t6_stat_stall", 64'(stat_stall), 64'd4);
`endif
    tick();
    n = 0;
    while (n < 300 && !rsp_valid) begin
      tick();
      n++;
    end
    check("t3_first_rsp", 64'(n < 300), 64'd1);
    repeat (20) tick();
    rsp_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (rsp_valid) pops++;
      tick();
    end
    check("t3_pops", 64'(pops), 64'd16);
    req_valid = '0;
    repeat (L + 60) tick();
    // Credits fully returned: another burst is capped at 16 again.
    rsp_ready = 1'b0;
    offer(0, 20, 100, acc);
    check("t3_reaccepted", 64'(acc), 64'd16);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (L + 40) tick();

    // 4: credits==1 with pop and transfer in the same cycle
    pulse_reset();
    rsp_ready = 1'b0;
    offer(1, 30, 15, acc);
    req_valid = '0;
    check("t4_issued", 64'(acc), 64'd15);
    repeat (L + 25) tick();
    set_key(1, 8'd7, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("t4_ready_last", 64'(req_ready), 64'h2);
    check("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    tick();
    set_key(1, 8'd9, 32'hBEEF0001, 32'hBEEF0002, 32'hBEEF0003);
    @(negedge CLK);
    check("t4_ready_next", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    repeat (L + 40) tick();

    // 5: reset 50 cycles after issue start discards in-flight results
    pulse_reset();
    rsp_ready = 1'b1;
    offer(3, 10, 100, acc);
    req_valid = '0;
    check("t5_issued", 64'(acc), 64'd10);
    repeat (40) tick();
    pulse_reset();
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (rsp_valid) stalls++;
      tick();
    end
    check("t5_no_rsp", 64'(stalls), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
